// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, FSM states,
// ALU operation codes and the bundle of control strobes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_ADDI = 3'b010,
    OP_LD   = 3'b011,
    OP_ST   = 3'b100,
    OP_BEQZ = 3'b101,
    OP_JMP  = 3'b110,
    OP_HLT  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       halted;
  } ctrl_t;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from the controller state and latched opcode.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e  state_i,
  input  opcode_e op_i,
  input  logic    rd_zero_i,
  input  logic    mem_ready_i,
  output ctrl_t   ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ir_write = mem_ready_i;
        ctrl_o.pc_write = mem_ready_i;
      end
      S_EXEC: begin
        ctrl_o.alu_op = (op_i == OP_SUB) ? ALU_SUB : ALU_ADD;
        ctrl_o.b_sel  = (op_i == OP_ADDI) || is_mem_op(op_i);
        ctrl_o.a_sel  = is_mem_op(op_i);
      end
      S_MEM: begin
        // Held for the whole wait so memory sees a stable request.
        ctrl_o.mem_read  = (op_i == OP_LD);
        ctrl_o.mem_write = (op_i == OP_ST);
      end
      S_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = (op_i == OP_LD);
      end
      S_BRANCH: begin
        ctrl_o.pc_src   = 1'b1;
        ctrl_o.pc_write = (op_i == OP_JMP) || ((op_i == OP_BEQZ) && rd_zero_i);
      end
      S_HALT: begin
        ctrl_o.halted = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle CPU control FSM: holds state, latched opcode and the retired
// instruction counter; strobe decode lives in ctrl_decode.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       mem_ready,
  input  logic       rd_zero,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       halted,
  output logic [7:0] retired
);

  state_e     state_q, state_d;
  opcode_e    op_q;
  logic [7:0] retired_q;
  logic       retire;
  opcode_e    instr_op;
  ctrl_t      dec;
  ctrl_t      ctrl;
  logic       unused_instr_fields;

  assign instr_op            = opcode_e'(instr[7:5]);
  assign unused_instr_fields = ^instr[4:0];

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        // op_q is not loaded yet, so branch on the live instruction.
        case (instr_op)
          OP_BEQZ, OP_JMP: state_d = S_BRANCH;
          OP_HLT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC:   state_d = is_mem_op(op_q) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_LD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= OP_ADD;
      retired_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= instr_op;
      if (retire) retired_q <= retired_q + 8'd1;
    end
  end

  ctrl_decode u_decode (
    .state_i     (state_q),
    .op_i        (op_q),
    .rd_zero_i   (rd_zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (dec)
  );

  // Reset silences every strobe immediately, aborting any in-flight access.
  assign ctrl    = rst ? '0 : dec;
  assign retired = rst ? 8'd0 : retired_q;

  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign a_sel      = ctrl.a_sel;
  assign b_sel      = ctrl.b_sel;
  assign alu_op     = ctrl.alu_op;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign halted     = ctrl.halted;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: table vectors, corner sequences and
// random instruction streams checked against an instruction-level model.
module tb_cpu_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic [7:0] instr;
  logic       mem_ready;
  logic       rd_zero;
  logic       ir_write, pc_write, pc_src, a_sel, b_sel;
  logic [1:0] alu_op;
  logic       mem_read, mem_write, mem_to_reg, reg_write, halted;
  logic [7:0] retired;

  cpu_ctrl_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .rd_zero    (rd_zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .a_sel      (a_sel),
    .b_sel      (b_sel),
    .alu_op     (alu_op),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .halted     (halted),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       halted;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    mr;
  } step_t;

  typedef struct {
    logic [7:0] ins;
    bit         rdz;
    int         fw;
    int         mw;
    int         ncyc;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_ret  = 8'd0;
  step_t      seq[$];
  vec_t       tbl[10];

  function automatic outs_t got_outs();
    outs_t g;
    g = '{ir_write, pc_write, pc_src, a_sel, b_sel, alu_op,
          mem_read, mem_write, mem_to_reg, reg_write, halted};
    return g;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at cycle start, check settled outputs, advance.
  task automatic step(input logic [7:0] ins, input bit rdz, input bit mr, input bit r,
                      input outs_t exp_o, input logic [7:0] exp_r, input string tag);
    instr = ins; rd_zero = rdz; mem_ready = mr; rst = r;
    #2;
    chk({tag, "_outs"}, 16'(got_outs()), 16'(exp_o));
    chk({tag, "_retired"}, 16'(retired), 16'(exp_r));
    chk({tag, "_rw_excl"}, 16'({mem_read & mem_write, reg_write & mem_write}), 16'd0);
    @(negedge clk);
  endtask

  function automatic int latency(input logic [2:0] op, input int fw, input int mw);
    case (op)
      3'd3:       return 5 + fw + mw;
      3'd4:       return 4 + fw + mw;
      3'd5, 3'd6: return 3 + fw;
      default:    return 4 + fw;
    endcase
  endfunction

  // Expected per-cycle strobes for one instruction, from the instruction semantics.
  function automatic void build(input logic [2:0] op, input bit rdz, input int fw, input int mw);
    outs_t o;
    seq.delete();
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mem_read = 1'b1; seq.push_back('{o, 1'b0});
    end
    o = '0; o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    seq.push_back('{o, 1'b1});
    o = '0; seq.push_back('{o, 1'($urandom)});
    if (op <= 3'd2) begin
      o = '0; o.alu_op = (op == 3'd1) ? 2'b01 : 2'b00; o.b_sel = (op == 3'd2);
      seq.push_back('{o, 1'($urandom)});
      o = '0; o.reg_write = 1'b1; seq.push_back('{o, 1'($urandom)});
    end else if (op <= 3'd4) begin
      o = '0; o.a_sel = 1'b1; o.b_sel = 1'b1; seq.push_back('{o, 1'($urandom)});
      o = '0; o.mem_read = (op == 3'd3); o.mem_write = (op == 3'd4);
      for (int i = 0; i < mw; i++) seq.push_back('{o, 1'b0});
      seq.push_back('{o, 1'b1});
      if (op == 3'd3) begin
        o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; seq.push_back('{o, 1'($urandom)});
      end
    end else begin
      o = '0; o.pc_src = 1'b1; o.pc_write = (op == 3'd6) || rdz;
      seq.push_back('{o, 1'($urandom)});
    end
  endfunction

  task automatic run_instr(input logic [7:0] ins, input bit rdz, input int fw,
                           input int mw, input int ncyc, input string tag);
    step_t s;
    build(ins[7:5], rdz, fw, mw);
    for (int c = 0; c < ncyc; c++) begin
      s.o = '0; s.o.mem_read = 1'b1; s.mr = 1'b0;
      if (c < seq.size()) s = seq[c];
      step(ins, rdz, s.mr, 1'b0, s.o, exp_ret, tag);
    end
    exp_ret = exp_ret + 8'd1;
  endtask

  task automatic do_reset(input string tag);
    outs_t z;
    z = '0;
    step(8'($urandom), 1'($urandom), 1'b1, 1'b1, z, 8'd0, {tag, "_rst0"});
    step(8'($urandom), 1'($urandom), 1'b1, 1'b1, z, 8'd0, {tag, "_rst1"});
    exp_ret = 8'd0;
  endtask

  initial begin
    outs_t o;
    rst = 1'b1; instr = 8'd0; mem_ready = 1'b0; rd_zero = 1'b0;
    tbl[0] = '{8'b010_01_111, 1'b0, 0, 0, 4};
    tbl[1] = '{8'b000_01_110, 1'b0, 0, 0, 4};
    tbl[2] = '{8'b001_10_001, 1'b1, 2, 0, 6};
    tbl[3] = '{8'b011_10_010, 1'b0, 0, 3, 8};
    tbl[4] = '{8'b011_11_101, 1'b0, 0, 0, 5};
    tbl[5] = '{8'b100_01_011, 1'b0, 0, 0, 4};
    tbl[6] = '{8'b100_00_110, 1'b1, 1, 2, 7};
    tbl[7] = '{8'b101_00_100, 1'b1, 0, 0, 3};
    tbl[8] = '{8'b101_00_100, 1'b0, 0, 0, 3};
    tbl[9] = '{8'b110_00_001, 1'b0, 1, 0, 4};

    @(negedge clk);
    do_reset("init");
    foreach (tbl[i])
      run_instr(tbl[i].ins, tbl[i].rdz, tbl[i].fw, tbl[i].mw, tbl[i].ncyc,
                $sformatf("tbl%0d", i));

    // HLT: retires on entering HALT, then stays halted with no strobes.
    o = '0; o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    step(8'b111_00_000, 1'b0, 1'b1, 1'b0, o, exp_ret, "hlt_fetch");
    step(8'b111_00_000, 1'b0, 1'b0, 1'b0, '0, exp_ret, "hlt_decode");
    exp_ret = exp_ret + 8'd1;
    o = '0; o.halted = 1'b1;
    for (int i = 0; i < 20; i++)
      step(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, o, exp_ret, "hlt_hold");
    do_reset("post_hlt");

    // Reset during an ST memory wait aborts it without retiring.
    run_instr(8'b000_01_010, 1'b0, 0, 0, 4, "pre_st_add");
    o = '0; o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    step(8'b100_01_011, 1'b0, 1'b1, 1'b0, o, exp_ret, "st_fetch");
    step(8'b100_01_011, 1'b0, 1'b0, 1'b0, '0, exp_ret, "st_decode");
    o = '0; o.a_sel = 1'b1; o.b_sel = 1'b1;
    step(8'b100_01_011, 1'b0, 1'b0, 1'b0, o, exp_ret, "st_exec");
    o = '0; o.mem_write = 1'b1;
    step(8'b100_01_011, 1'b0, 1'b0, 1'b0, o, exp_ret, "st_memwait");
    step(8'b100_01_011, 1'b0, 1'b1, 1'b1, '0, 8'd0, "st_abort0");
    step(8'b100_01_011, 1'b0, 1'b1, 1'b1, '0, 8'd0, "st_abort1");
    exp_ret = 8'd0;
    o = '0; o.mem_read = 1'b1;
    step(8'b100_01_011, 1'b0, 1'b0, 1'b0, o, exp_ret, "st_release");

    for (int n = 0; n < 300; n++) begin
      logic [7:0] ins;
      int fw, mw;
      ins = 8'($urandom);
      ins[7:5] = 3'($urandom_range(0, 6));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      run_instr(ins, 1'($urandom), fw, mw, latency(ins[7:5], fw, mw), "rand");
    end

    do_reset("pre_wrap");
    for (int n = 0; n < 256; n++)
      run_instr(8'b110_00_000 | 8'($urandom_range(0, 31)), 1'($urandom), 0, 0, 3, "wrap_jmp");
    #1;
    chk("wrap256", 16'(retired), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 instr  in  8  current instruction: opcode [7:5], rd [4:3], offset [2:0] (also rs = [1:0]).
REQ-005 mem_ready  in  1  memory has completed the current read/write this cycle.
REQ-006 rd_zero  in  1  register-file value of rd equals 0.
REQ-007 ir_write, pc_write  out  1 each  load IR / load PC.
REQ-008 pc_src  out  1  0 = PC+1, 1 = PC+1+sign_ext(offset).
REQ-009 a_sel  out  1  ALU A operand: 0 = rd, 1 = R0.
REQ-010 b_sel  out  1  ALU B operand: 0 = rs, 1 = 8-bit sign-extended offset.
REQ-011 alu_op  out  2  00 ADD, 01 SUB, 10/11 unused.
REQ-012 mem_read, mem_write, mem_to_reg, reg_write, halted  out  1 each.
REQ-013 retired  out  8  count of completed instructions.

Function
REQ-014 Opcodes SHALL be: 000 ADD rd=rd+rs; 001 SUB rd=rd-rs; 010 ADDI rd=rd+sext(off); 011 LD rd=mem[R0+sext(off)]; 100 ST mem[R0+sext(off)]=rd; 101 BEQZ branch if rd==0; 110 JMP; 111 HLT.
REQ-015 States SHALL be FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT; opcode latched into op_q on DECODE.
REQ-016 FETCH: mem_read=1; stay while mem_ready=0; on mem_ready=1 assert ir_write=1, pc_write=1, pc_src=0 that cycle and go to DECODE.
REQ-017 DECODE: no strobes; next = EXEC for 000-100, BRANCH for 101/110, HALT for 111.
REQ-018 EXEC: alu_op=01 only for SUB, else 00; b_sel=1 for ADDI/LD/ST; a_sel=1 for LD/ST; next = MEM for LD/ST, else WB.
REQ-019 MEM: mem_read=1 (LD) or mem_write=1 (ST), held stable while mem_ready=0; on mem_ready=1 go to WB (LD) or FETCH (ST).
REQ-020 WB: reg_write=1 for one cycle; mem_to_reg=1 only for LD; next FETCH.
REQ-021 BRANCH: pc_src=1; pc_write=1 if JMP, or BEQZ with rd_zero=1; next FETCH.
REQ-022 HALT: halted=1, all strobes 0, remain until rst.
REQ-023 Minimum latencies (mem_ready=1 immediately): ALU ops 4 cycles, LD 5, ST 4, BEQZ/JMP 3; each wait cycle adds one.
REQ-024 retired SHALL increment by 1 on leaving WB, on leaving MEM for ST, on leaving BRANCH, and on entering HALT; it wraps 255->0.
REQ-025 At most one of mem_read/mem_write SHALL be high in any cycle; reg_write SHALL never coincide with mem_write.

Reset
REQ-026 While rst=1, all outputs SHALL be 0 and retired=0; state SHALL become FETCH on the reset edge.
REQ-027 rst asserted in any state, including a MEM wait, SHALL abort the instruction with no further strobes and no retired increment.
REQ-028 The first cycle after rst deasserts SHALL be FETCH with mem_read=1.

Structure
REQ-029 Opcode constants, state encoding and alu_op codes SHALL live in shared package cpu_ctrl_pkg.
REQ-030 Output decode SHALL be a combinational sub-module ctrl_decode(state, op_q, rd_zero); cpu_ctrl_fsm holds state, op_q and retired.

Verification
REQ-031 ADDI r1,-1 (instr 8'b010_01_111), mem_ready=1 -> FETCH,DECODE,EXEC(b_sel=1,alu_op=00),WB(reg_write=1); retired 0->1.
REQ-032 LD r2 (8'b011_10_010), mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
REQ-033 BEQZ (8'b101_00_100): rd_zero=1 -> pc_write=1, pc_src=1 in BRANCH; rd_zero=0 -> pc_write=0; both retire.
REQ-034 rst pulsed during MEM of ST -> mem_write drops next cycle, retired unchanged-then-0, FETCH after release.
REQ-035 HLT (8'b111_00_000) -> halted=1 held 20 cycles, no strobes; 256 retired instructions -> retired reads 0.
